rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It succeeds the fixed 8-to-1 combinational selector in the datapath. Two selection modes are supported:
- **Fixed:** an externally driven select.
- **Round-robin:** built-in fair arbitration.

The selected beat is captured into a one-deep output register, so the block can sit between pipeline stages that apply backpressure.

## Interface
Parameters:
- W, 16, data width per channel
- N, 8, number of input channels (N >= 2)
- SW, 3, select/channel-index width; must satisfy 2^SW >= N

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- s  input  SW  channel select, used in fixed mode only
- in_data  input  N*W  flattened inputs; channel k occupies bits [k*W+W-1 : k*W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit high
- out_data  output  W  registered selected data
- out_ch  output  SW  index of the channel that produced out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts the beat

## Operation
- **Reset values** (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. While rst_n is low, in_ready is forced to 0.
- **Accept condition:** accept = !out_valid || out_ready. The output register is either empty or being drained in the same cycle.
- **Grant, fixed mode (mode=0):**
  - Grant channel s only if s < N and in_valid[s]=1.
  - s >= N gives no grant.
  - ptr is not modified in fixed mode.
- **Grant, round-robin mode (mode=1):**
  - Scan channels ptr, ptr+1, ..., wrapping modulo N (not modulo 2^SW).
  - The first channel with in_valid=1 is granted.
  - If no channel is valid, there is no grant.
- **in_ready[g]:** equals accept && grant==g. It is combinational from in_valid, mode, s, ptr and the output-register state.
- **Transfer:** occurs on in_valid[g] && in_ready[g]. At the next clk edge:
  - out_data <= channel g data
  - out_ch <= g
  - out_valid <= 1
  - in round-robin mode only, ptr <= (g+1) mod N; when g = N-1, ptr wraps to 0.
- **Drain:** out_valid && out_ready with no new transfer clears out_valid at the next edge. out_data and out_ch keep their last values.
- **Simultaneous drain and transfer:** the register is reloaded and out_valid stays 1.
- **Stall:** while out_valid && !out_ready:
  - out_data and out_ch are held stable.
  - All in_ready bits are 0.
  - Changes on mode, s or in_valid have no effect on the held beat.
- **Mode switch:** takes effect on the next grant decision. ptr retains its value across fixed-mode periods.
- **Reset mid-operation:** any held beat is discarded immediately (out_valid drops asynchronously) and ptr returns to 0.

## Timing
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 beat/cycle while out_ready=1 and some granted channel is valid.
- There are no combinational paths from in_data to out_data.
- There is a combinational path out_ready -> in_ready. This is the only ready-side combinational dependency.
- Grant logic is a single-cycle priority scan rotated by ptr.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n=0 while out_valid=1.
  - Response: out_valid, out_data and out_ch go to 0 without waiting for a clock edge; in_ready=0.
  - After release with in_valid=0: all outputs remain at reset values.
- **Fixed select (N=8, W=16):**
  - Stimulus: mode=0, s=5, in_valid=8'hFF, channel k data = 16'h1111*k, out_ready=1.
  - Response: in_ready=8'b0010_0000; next cycle out_data=16'h5555, out_ch=5, out_valid=1.
- **Round-robin sweep:**
  - Stimulus: mode=1, in_valid=8'hFF, out_ready=1 for 10 cycles from reset.
  - Response: out_ch sequence 0,1,2,3,4,5,6,7,0,1.
- **Sparse round-robin:**
  - Stimulus: mode=1, in_valid=8'b1000_0100, ptr=0.
  - Response: grants 2, 7, 2, 7. ptr becomes 3, then 0 (wrap), then 3.
- **Backpressure:**
  - Stimulus: after a beat with out_data=16'h3333, hold out_ready=0 for 3 cycles.
  - Response during stall: out_data and out_ch stay stable; in_ready=0 every stalled cycle.
  - Stimulus: raise out_ready in cycle 4.
  - Response: a new beat is accepted in the same cycle and out_valid stays 1.
- **Non-power-of-two (N=5, SW=3):**
  - Fixed mode with s=6 and in_valid=5'h1F: no in_ready bit is asserted and out_valid stays 0.
  - Round-robin mode after a grant of channel 4: ptr=0, and the next grant is channel 0.

Source files
------------

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel registered mux with fixed-select or round-robin grant and valid/ready handshakes
module rr_mux_n #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);
    logic [SW-1:0]  ptr, gnt;
    logic           gnt_ok, accept, xfer;
    logic [W-1:0]   sel_data;
    logic [2*N-1:0] rot;
    int             j;

    assign accept = !out_valid || out_ready;
    assign xfer   = accept && gnt_ok;

    // rot[i] is the valid of channel (ptr+i) mod N; scanning down lets the channel nearest ptr win
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = '0;
        j      = 0;
        rot    = {in_valid, in_valid} >> ptr;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            j = (j >= N) ? j - N : j;
            if (mode && rot[i]) begin
                gnt_ok = 1'b1;
                gnt    = SW'(j);
            end
            if (!mode && int'(s) == i && in_valid[i]) begin
                gnt_ok = 1'b1;
                gnt    = SW'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            sel_data    = (int'(gnt) == k) ? in_data[k*W +: W] : sel_data;
            in_ready[k] = rst_n && xfer && int'(gnt) == k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data <= sel_data;
                out_ch   <= gnt;
            end
            if (accept)
                out_valid <= xfer;
            if (xfer && mode)
                ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: scoreboard bench for rr_mux_n (N=8 main instance, N=5 non-power-of-two instance)
module tb_rr_mux_n;
    typedef struct {
        int          c;
        logic [15:0] d;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   s = '0;
    logic [127:0] in_data = '0;
    logic [7:0]   in_valid = '0;
    logic [7:0]   in_ready;
    logic [15:0]  out_data;
    logic [2:0]   out_ch;
    logic         out_valid;
    logic         out_ready = 1'b0;

    logic         b_mode = 1'b0;
    logic [2:0]   b_s = '0;
    logic [79:0]  b_in_data = '0;
    logic [4:0]   b_in_valid = '0;
    logic [4:0]   b_in_ready;
    logic [15:0]  b_out_data;
    logic [2:0]   b_out_ch;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;

    int    total = 0;
    int    bad = 0;
    beat_t sb[$];
    logic  mv = 1'b0;
    int    mptr = 0;

    always #5 clk = ~clk;

    rr_mux_n #(.W(16), .N(8), .SW(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_n #(.W(16), .N(5), .SW(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .s(b_s), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mgrant(input logic md, input logic [2:0] sel, input logic [7:0] v, input int p);
        if (!md)
            return v[sel] ? int'(sel) : -1;
        for (int i = 0; i < 8; i++)
            if (v[(p + i) % 8])
                return (p + i) % 8;
        return -1;
    endfunction

    // one clock: check against the model before the edge, then advance to just after the edge
    task automatic cycle();
        int         g;
        logic       acc;
        logic [7:0] er;
        beat_t      b;
        @(negedge clk);
        acc = !mv || out_ready;
        g   = mgrant(mode, s, in_valid, mptr);
        er  = (acc && g >= 0) ? (8'h01 << g) : 8'h00;
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, mv);
        if (mv && sb.size() > 0) begin
            chk("out_data", out_data, sb[0].d);
            chk("out_ch", out_ch, sb[0].c);
            if (out_ready)
                void'(sb.pop_front());
        end
        if (er != 0) begin
            b.c = g;
            b.d = in_data[g*16 +: 16];
            sb.push_back(b);
            if (mode)
                mptr = (g + 1) % 8;
            mv = 1'b1;
        end else if (out_ready) begin
            mv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = '0;
        b_in_valid = '0;
        rst_n      = 1'b0;
        mv         = 1'b0;
        mptr       = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 8; k++)
            in_data[k*16 +: 16] = 16'(16'h1111 * k);
    endtask

    initial begin
        set_ramp();
        in_valid = 8'hFF;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        repeat (2) cycle();

        // fixed select, channel 5
        mode = 1'b0; s = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        #1 chk("fix_ready", in_ready, 8'b0010_0000);
        cycle();
        chk("fix_data", out_data, 16'h5555);
        chk("fix_ch", out_ch, 5);
        in_valid = '0;
        cycle();

        // asynchronous reset while a beat is held
        s = 3'd2; in_valid = 8'h04; out_ready = 1'b0;
        cycle();
        chk("hold_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_ch", out_ch, 0);
        chk("arst_in_ready", in_ready, 0);
        out_ready = 1'b1;
        do_reset();
        cycle();

        // round-robin sweep, all valid
        do_reset();
        mode = 1'b1; in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("rr_seq", out_ch, i % 8);
        end
        in_valid = '0;
        cycle();

        // sparse round-robin from ptr=0
        do_reset();
        mode = 1'b1; in_valid = 8'b1000_0100;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("sparse_seq", out_ch, (i % 2) ? 7 : 2);
        end
        in_valid = '0;
        cycle();

        // backpressure
        mode = 1'b0; s = 3'd3; in_valid = 8'h08;
        cycle();
        chk("bp_data", out_data, 16'h3333);
        out_ready = 1'b0; in_valid = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            mode = i[0]; s = 3'(i + 1);
            cycle();
            chk("bp_hold", out_data, 16'h3333);
        end
        mode = 1'b0; s = 3'd1; out_ready = 1'b1;
        cycle();
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_data", out_data, 16'h1111);
        in_valid = '0;
        repeat (2) cycle();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            mode = 1'($urandom);
            s = 3'($urandom);
            in_valid = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++)
                in_data[k*16 +: 16] = 16'($urandom);
            cycle();
        end
        in_valid = '0; out_ready = 1'b1;
        repeat (2) cycle();
        chk("sb_empty", sb.size(), 0);

        // N=5: out-of-range select, then round-robin wrap after channel 4
        do_reset();
        for (int k = 0; k < 5; k++)
            b_in_data[k*16 +: 16] = 16'(16'hA0 + k);
        b_mode = 1'b0; b_s = 3'd6; b_in_valid = 5'h1F; b_out_ready = 1'b1;
        #1 chk("n5_fix_ready", b_in_ready, 0);
        @(posedge clk); #1;
        chk("n5_fix_valid", b_out_valid, 0);
        b_mode = 1'b1; b_in_valid = 5'h10;
        #1 chk("n5_rr_ready4", b_in_ready, 5'h10);
        @(posedge clk); #1;
        chk("n5_rr_ch4", b_out_ch, 4);
        b_in_valid = 5'h1F;
        #1 chk("n5_rr_ready0", b_in_ready, 5'h01);
        @(posedge clk); #1;
        chk("n5_rr_ch0", b_out_ch, 0);
        chk("n5_rr_data0", b_out_data, 16'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
